therm_decoder_seq: RTL
======================

# therm_decoder_seq

Sequential decoder for the sorted (thermometer) words produced by the `sorter2b`/`sorter3b`/`sorter4b` family. It accepts one W-bit thermometer word per transaction over a valid/ready handshake and scans it serially, one bit per clock. It returns the binary count of ones and a flag marking a malformed (non-thermometer) word. It sits downstream of a sorter and converts its unary result back to binary.

## Interface
Parameters:
- `W`, default 4: input word width, W ≥ 2.
- `CW`, default `$clog2(W+1)`: count width. It holds 0..W, so CW = 3 when W = 4.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: the upstream word is valid.
- `in_ready` output 1: the block can accept a word.
- `in_therm` input W: thermometer word. Ones are packed at the LSB end, e.g. count 2 = 4'b0011.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_cnt` output CW: number of ones in the accepted word.
- `out_err` output 1: 1 when the accepted word is not a legal thermometer code.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `in_therm` into the shift register and clear the count and error accumulators.
  - Clear the bit index and the "zero seen" flag.
  - Go to SHIFT.
- SHIFT:
  - Examine one bit per cycle, LSB first, for exactly W cycles.
  - For each bit b: count += b.
  - If b=1 and a 0 was already seen, set err.
  - If b=0, set "zero seen".
  - After bit W-1, go to DONE.
- DONE:
  - `out_valid`=1, with `out_cnt`/`out_err` driven from registers.
  - On `out_ready`, go to IDLE.
- Legal words are exactly the W+1 patterns {0…0, 0…01, …, 1…1}. Every other pattern sets `out_err`=1.
- `out_cnt` is always the popcount, whether or not the word is legal.
- `in_ready`=0 in SHIFT and DONE. Changes on `in_therm`/`in_valid` in those states are ignored.
- Count width: the accumulator is CW bits and cannot overflow, since the maximum is W.
- Reset (asserted at any time, including mid-SHIFT or DONE):
  - Go to IDLE immediately.
  - `out_valid`=0, `out_cnt`=0, `out_err`=0.
  - The in-flight word is discarded with no partial result.
  - `in_ready`=1 (IDLE) once reset has taken effect.

## Timing
- The acceptance edge is E0. Edges E1..EW each process one bit, bit i at E(i+1).
- `out_valid` rises after EW: latency is W cycles from acceptance to result valid.
- The result transfers on the first edge with `out_valid && out_ready`.
  - The FSM returns to IDLE at that edge.
  - `out_valid` drops after that edge.
  - `in_ready` rises after that edge.
- Minimum period is W+2 cycles per word: accept, W shift cycles, one DONE cycle with `out_ready`=1. No overlap between result hold and new acceptance.
- While `out_valid`=1 and `out_ready`=0, `out_cnt` and `out_err` stay stable for any number of cycles.
- `out_valid`, `out_cnt`, `out_err` and `in_ready` are registered or decoded only from FSM state. There are no combinational paths from inputs to outputs.

## Test plan
- W=4, `in_therm`=4'b0011, `out_ready`=1 → `out_valid` 4 cycles after acceptance, `out_cnt`=2, `out_err`=0, `in_ready` back to 1 one cycle later.
- `in_therm`=4'b0101, then 4'b0000, then 4'b1111 → results (2,1), (0,0), (4,0) respectively, each with 6-cycle spacing.
- Backpressure: accept 4'b0111 with `out_ready`=0 for 5 cycles after `out_valid` rises → `out_cnt`=3, `out_err`=0 held stable, `in_ready`=0 throughout, single transfer when `out_ready`=1.
- Ignored input: toggle `in_therm` and hold `in_valid`=1 during SHIFT → no second acceptance, and the result reflects only the captured word.
- Reset mid-operation: assert `rst_n`=0 two cycles into SHIFT → `out_valid`=0, `out_cnt`=0, `out_err`=0 immediately, no result after release, `in_ready`=1.
- Exhaustive: for x=0..15, feed `sorter4b(x)` → `out_cnt`=popcount(x), `out_err`=0. Then feed raw x → `out_err` = (x ≠ `sorter4b(x)`).

Source files
------------

// File: rtl/therm_decoder_seq.sv
// Serial thermometer-code decoder: scans one accepted word LSB first, one bit per
// clock, and returns the popcount plus a flag for non-thermometer patterns.
module therm_decoder_seq #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_therm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_cnt,
    output logic          out_err
);

    localparam int IW = (W > 2) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          zero_q, zero_d;
    logic          bit_cur;

    assign bit_cur = sh_q[0];

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sh_d    = in_therm;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + CW'(bit_cur);
                // A one after any zero means the ones are not packed at the LSB end.
                if (bit_cur && zero_q) begin
                    err_d = 1'b1;
                end
                if (!bit_cur) begin
                    zero_d = 1'b1;
                end
                if (idx_q == IW'(W - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_cnt   = cnt_q;
    assign out_err   = err_q;

endmodule
